// File: rtl/apb_intc.sv
// APB interrupt controller: latches level/edge sources, masks and prioritises them
// (lowest index wins) and exposes a claim/complete register pair to software.
module apb_intc #(
   parameter int NUM_SRC = 40,
   parameter int ID_W    = 6
) (
   input  logic               pclk,
   input  logic               presetn,
   input  logic               psel,
   input  logic               penable,
   input  logic [11:0]        paddr,
   input  logic               pwrite,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   input  logic [NUM_SRC-1:0] intc_src,
   output logic               intc_irq,
   output logic [ID_W-1:0]    intc_id
);

   localparam logic [9:0] W_PEND_LO  = 10'd0;
   localparam logic [9:0] W_PEND_HI  = 10'd1;
   localparam logic [9:0] W_EN_LO    = 10'd2;
   localparam logic [9:0] W_EN_HI    = 10'd3;
   localparam logic [9:0] W_TYPE_LO  = 10'd4;
   localparam logic [9:0] W_TYPE_HI  = 10'd5;
   localparam logic [9:0] W_INSVC_LO = 10'd6;
   localparam logic [9:0] W_INSVC_HI = 10'd7;
   localparam logic [9:0] W_CLAIM    = 10'd8;
   localparam logic [9:0] W_THRESH   = 10'd9;

   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] en_q, en_d;
   logic [NUM_SRC-1:0] type_q, type_d;
   logic [NUM_SRC-1:0] insvc_q, insvc_d;
   logic [NUM_SRC-1:0] src_q, src_d;
   logic               thresh_q, thresh_d;
   logic               irq_q, irq_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic [9:0]         word;
   logic               wr_acc, rd_acc, claim_rd, claim_wr;
   logic [NUM_SRC-1:0] rise, cand, cand_low, claim_set, cmp_clr;
   logic [ID_W-1:0]    cand_id;
   logic [63:0]        pend_w, en_w, type_w, insvc_w;
   logic               addr_unused;

   assign word        = paddr[11:2];
   assign addr_unused = ^paddr[1:0];
   assign wr_acc      = psel & penable & pwrite;
   assign rd_acc      = psel & penable & ~pwrite;
   assign claim_rd    = rd_acc & (word == W_CLAIM);
   assign claim_wr    = wr_acc & (word == W_CLAIM);
   assign rise        = intc_src & ~src_q;

   // Candidate selection: isolate the lowest set bit and encode its ID.
   always_comb begin
      cand     = pend_q & en_q & ~insvc_q;
      cand_low = cand & (~cand + NUM_SRC'(1));
      cand_id  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (cand[i]) cand_id = ID_W'(i + 1);
      end
   end

   always_comb begin
      claim_set = claim_rd ? cand_low : '0;
      cmp_clr   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (claim_wr && (pwdata[ID_W-1:0] == ID_W'(i + 1))) cmp_clr[i] = 1'b1;
      end
   end

   // Split 64-bit register pairs: source i lives in the lo word below 32, else hi.
   always_comb begin
      en_d   = en_q;
      type_d = type_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (wr_acc && (word == ((i < 32) ? W_EN_LO : W_EN_HI)))
            en_d[i] = pwdata[i % 32];
         if (wr_acc && (word == ((i < 32) ? W_TYPE_LO : W_TYPE_HI)))
            type_d[i] = pwdata[i % 32];
      end
   end

   always_comb begin
      src_d    = intc_src;
      pend_d   = (type_q & (rise | (pend_q & ~claim_set))) | (~type_q & intc_src);
      pend_d   = pend_d & ~(type_d & ~type_q);
      insvc_d  = (insvc_q | claim_set) & ~cmp_clr;
      thresh_d = (wr_acc && (word == W_THRESH)) ? pwdata[0] : thresh_q;
      irq_d    = thresh_q & (|cand);
      id_d     = cand_id;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pend_q   <= '0;
         en_q     <= '0;
         type_q   <= '0;
         insvc_q  <= '0;
         src_q    <= '0;
         thresh_q <= 1'b0;
         irq_q    <= 1'b0;
         id_q     <= '0;
      end else begin
         pend_q   <= pend_d;
         en_q     <= en_d;
         type_q   <= type_d;
         insvc_q  <= insvc_d;
         src_q    <= src_d;
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
         id_q     <= id_d;
      end
   end

   assign pend_w  = 64'(pend_q);
   assign en_w    = 64'(en_q);
   assign type_w  = 64'(type_q);
   assign insvc_w = 64'(insvc_q);

   always_comb begin
      prdata = '0;
      if (rd_acc) begin
         case (word)
            W_PEND_LO:  prdata = pend_w[31:0];
            W_PEND_HI:  prdata = pend_w[63:32];
            W_EN_LO:    prdata = en_w[31:0];
            W_EN_HI:    prdata = en_w[63:32];
            W_TYPE_LO:  prdata = type_w[31:0];
            W_TYPE_HI:  prdata = type_w[63:32];
            W_INSVC_LO: prdata = insvc_w[31:0];
            W_INSVC_HI: prdata = insvc_w[63:32];
            W_CLAIM:    prdata = 32'(cand_id);
            W_THRESH:   prdata = {31'b0, thresh_q};
            default:    prdata = '0;
         endcase
      end
   end

   assign intc_irq = irq_q;
   assign intc_id  = id_q;

endmodule
